iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter STEP, default 4, maximum bits shifted per cycle; power of two, 1..WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a shift; accepted only in IDLE.
REQ-006 SHALL have port imm_mode  input  1  1 = immediate operand form, 0 = register form.
REQ-007 SHALL have port operand  input  12  immediate operand: rot = [11:8], imm8 = [7:0].
REQ-008 SHALL have port value  input  WIDTH  register-form data to shift.
REQ-009 SHALL have port amount  input  8  register-form shift amount, unsigned.
REQ-010 SHALL have port shift_type  input  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5-7 none.
REQ-011 SHALL have port carry_in  input  1  current C flag.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse; result and carry_out valid.
REQ-014 SHALL have port result  output  WIDTH  shifted value, held until next accepted start.
REQ-015 SHALL have port carry_out  output  1  shifter carry, held with result.

Function
REQ-016 SHALL implement states IDLE, SHIFT, DONE; start with busy high is ignored, no effect.
REQ-017 On start in IDLE with imm_mode=1, SHALL load data = zero-extended imm8, type ROR, amount = 2*rot; value, amount, shift_type are ignored.
REQ-018 On accept, SHALL compute effective count eff: LSL/LSR/ASR min(amount, WIDTH+1); ROR amount mod WIDTH; RRX and types 5-7 eff = 0.
REQ-019 On accept with eff = 0, SHALL go to DONE with: LSL/LSR/ASR/types 5-7 -> result = data, C = carry_in; ROR with amount = 0 -> data, C = carry_in; ROR with amount nonzero multiple of WIDTH -> data, C = data[WIDTH-1]; RRX -> {carry_in, data[WIDTH-1:1]}, C = data[0].
REQ-020 On accept with eff > 0, SHALL load working register, remaining = eff, go to SHIFT.
REQ-021 In SHIFT, each cycle SHALL shift by k = min(STEP, remaining), set C to last bit shifted out (ROR: new MSB), and decrement remaining by k; go to DONE when remaining reaches 0.
REQ-022 LSL/LSR SHALL fill zeros, ASR SHALL fill with the original sign bit, ROR SHALL rotate; thus LSL WIDTH -> 0, C = data[0]; LSR WIDTH -> 0, C = data[WIDTH-1]; LSL/LSR > WIDTH -> 0, C = 0; ASR >= WIDTH -> all sign bits, C = sign.
REQ-023 In DONE, SHALL assert done for exactly one cycle, then return to IDLE; start in the DONE cycle is ignored.
REQ-024 Latency from start-accept edge to done SHALL be 1 + ceil(eff/STEP) cycles.
REQ-025 result and carry_out SHALL change only at accept-derived update and SHIFT cycles, and SHALL hold from DONE until the next accepted start.

Reset
REQ-026 While reset is high at a clock edge, SHALL force state IDLE, busy 0, done 0, result 0, carry_out 0.
REQ-027 Reset during SHIFT or DONE SHALL abort the operation; no done pulse for it.
REQ-028 Reset SHALL take priority over a simultaneous start.

Verification (WIDTH=32, STEP=4)
REQ-029 LSL value 0x0000_0001, amount 4, cin 1 -> result 0x0000_0010, C 0, done 2 cycles after start.
REQ-030 LSR 0x8000_0000, amount 32 -> result 0, C 1, latency 9; amount 33 -> 0, C 0, latency 10.
REQ-031 ASR 0x8000_0000, amount 40 -> 0xFFFF_FFFF, C 1, latency 10.
REQ-032 imm_mode, operand 0x4FF -> 0xFF00_0000, C 1, latency 3; ROR amount 64 on 0x8000_0001, cin 0 -> 0x8000_0001, C 1, latency 1.
REQ-033 RRX 0x0000_0003, cin 1 -> 0x8000_0001, C 1, latency 1; type 6 -> value unchanged, C = cin.
REQ-034 Start LSL 20, pulse start again at cycle 2, assert reset at cycle 3 -> second start ignored, busy 0, done never pulses, result 0.

Source files
------------

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle barrel-style shifter that retires up to STEP bit
// positions per clock. Supports LSL, LSR, ASR, ROR, RRX and an immediate
// operand form (imm8 rotated right by 2*rot).
//
// Handshake: start is sampled only while busy is low (state IDLE); a start
// seen with busy high, including the DONE cycle, has no effect. done pulses
// high for exactly one cycle with result/carry_out valid, and both outputs
// then hold until the next accepted start.
module iter_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             imm_mode,
   input  logic [11:0]      operand,
   input  logic [WIDTH-1:0] value,
   input  logic [7:0]       amount,
   input  logic [2:0]       shift_type,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_LSL = 3'd0;
   localparam logic [2:0] OP_LSR = 3'd1;
   localparam logic [2:0] OP_ASR = 3'd2;
   localparam logic [2:0] OP_ROR = 3'd3;
   localparam logic [2:0] OP_RRX = 3'd4;

   // Shifts past WIDTH+1 look identical to WIDTH+1, so the count saturates there.
   localparam logic [7:0] MAX_CNT = 8'(WIDTH + 1);
   localparam logic [7:0] ROR_MASK = 8'(WIDTH - 1);
   localparam logic [7:0] STEP_CNT = 8'(STEP);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [7:0]       rem_q;
   logic [2:0]       op_q;

   logic             accept;
   logic [WIDTH-1:0] src_data;
   logic [2:0]       src_type;
   logic [7:0]       src_amt;
   logic [7:0]       eff;
   logic [WIDTH-1:0] imm_res;
   logic             imm_c;
   logic [7:0]       k_cnt;
   logic [WIDTH-1:0] step_val;
   logic             step_c;

   assign accept = start && (state_q == IDLE);

   // Operand selection and effective shift count for the request being accepted.
   always_comb begin
      src_data = imm_mode ? WIDTH'(operand[7:0]) : value;
      src_type = imm_mode ? OP_ROR : shift_type;
      src_amt  = imm_mode ? {3'b000, operand[11:8], 1'b0} : amount;
      case (src_type)
         OP_LSL, OP_LSR, OP_ASR: eff = (src_amt > MAX_CNT) ? MAX_CNT : src_amt;
         OP_ROR:                 eff = src_amt & ROR_MASK;
         default:                eff = 8'd0;
      endcase
   end

   // Result for requests that finish without any shift cycles.
   always_comb begin
      imm_res = src_data;
      imm_c   = carry_in;
      case (src_type)
         OP_ROR: imm_c = (src_amt == 8'd0) ? carry_in : src_data[WIDTH-1];
         OP_RRX: begin
            imm_res = {carry_in, src_data[WIDTH-1:1]};
            imm_c   = src_data[0];
         end
         default: begin
            imm_res = src_data;
            imm_c   = carry_in;
         end
      endcase
   end

   // One SHIFT cycle: apply k_cnt single-bit steps, carry tracks the last bit out.
   always_comb begin
      k_cnt    = (rem_q > STEP_CNT) ? STEP_CNT : rem_q;
      step_val = res_q;
      step_c   = carry_q;
      for (int i = 0; i < STEP; i++) begin
         if (8'(i) < k_cnt) begin
            case (op_q)
               OP_LSL: begin
                  step_c   = step_val[WIDTH-1];
                  step_val = {step_val[WIDTH-2:0], 1'b0};
               end
               OP_LSR: begin
                  step_c   = step_val[0];
                  step_val = {1'b0, step_val[WIDTH-1:1]};
               end
               OP_ASR: begin
                  step_c   = step_val[0];
                  step_val = {step_val[WIDTH-1], step_val[WIDTH-1:1]};
               end
               OP_ROR: begin
                  step_val = {step_val[0], step_val[WIDTH-1:1]};
                  step_c   = step_val[WIDTH-1];
               end
               default: begin
                  step_val = step_val;
                  step_c   = step_c;
               end
            endcase
         end
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_d = state_q;
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);
      case (state_q)
         IDLE:  if (start) state_d = (eff == 8'd0) ? DONE : SHIFT;
         SHIFT: if (rem_q <= STEP_CNT) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Working register doubles as the held result; updated on accept and in SHIFT.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         carry_q <= 1'b0;
         rem_q   <= 8'd0;
         op_q    <= 3'd0;
      end else if (accept) begin
         op_q <= src_type;
         if (eff == 8'd0) begin
            res_q   <= imm_res;
            carry_q <= imm_c;
            rem_q   <= 8'd0;
         end else begin
            res_q   <= src_data;
            carry_q <= carry_in;
            rem_q   <= eff;
         end
      end else if (state_q == SHIFT) begin
         res_q   <= step_val;
         carry_q <= step_c;
         rem_q   <= rem_q - k_cnt;
      end
   end

   assign result    = res_q;
   assign carry_out = carry_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed vector table, random ops against an arithmetic
// reference model, and hand-written busy/reset corner sequences.
module tb_iter_shifter;

   localparam int W = 32;
   localparam int S = 4;

   logic          clk;
   logic          reset;
   logic          start;
   logic          imm_mode;
   logic [11:0]   operand;
   logic [W-1:0]  value;
   logic [7:0]    amount;
   logic [2:0]    shift_type;
   logic          carry_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          carry_out;
   logic [1:0]    fsm_state;

   int checks = 0;
   int errors = 0;

   logic [W:0]    exp_q[$];
   logic [W-1:0]  hold_res;
   logic          hold_c;

   typedef struct {
      logic          imm;
      logic [11:0]   op;
      logic [W-1:0]  val;
      logic [7:0]    amt;
      logic [2:0]    ty;
      logic          cin;
      logic [W-1:0]  exp_res;
      logic          exp_c;
      int            exp_lat;
   } vec_t;

   vec_t vecs[$];

   iter_shifter #(.WIDTH(W), .STEP(S)) dut (
      .clk(clk), .reset(reset), .start(start), .imm_mode(imm_mode),
      .operand(operand), .value(value), .amount(amount),
      .shift_type(shift_type), .carry_in(carry_in), .busy(busy),
      .done(done), .result(result), .carry_out(carry_out),
      .fsm_state(fsm_state)
   );

   // Clock and global watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on wide vectors.
   function automatic void model(input logic imm, input logic [11:0] op,
                                 input logic [W-1:0] val, input logic [7:0] amt,
                                 input logic [2:0] ty, input logic cin,
                                 output logic [W-1:0] r, output logic c, output int lat);
      logic [W-1:0]        d;
      int                  n;
      int                  t;
      int                  eff;
      logic [63:0]         x;
      logic signed [63:0]  sx;
      d = imm ? {24'b0, op[7:0]} : val;
      t = imm ? 3 : int'(ty);
      n = imm ? 2 * int'(op[11:8]) : int'(amt);
      eff = 0;
      r = d;
      c = cin;
      case (t)
         0: begin
            eff = (n > W + 1) ? W + 1 : n;
            x = {32'b0, d} << eff;
            if (eff > 0) begin r = x[31:0]; c = x[32]; end
         end
         1: begin
            eff = (n > W + 1) ? W + 1 : n;
            x = {d, 32'b0} >> eff;
            if (eff > 0) begin r = x[63:32]; c = x[31]; end
         end
         2: begin
            eff = (n > W + 1) ? W + 1 : n;
            sx = {d, 32'b0};
            sx = sx >>> eff;
            if (eff > 0) begin r = sx[63:32]; c = sx[31]; end
         end
         3: begin
            eff = n % W;
            if (n != 0) begin
               if (eff == 0) c = d[W-1];
               else begin
                  r = (d >> eff) | (d << (W - eff));
                  c = r[W-1];
               end
            end
         end
         4: begin
            r = {cin, d[W-1:1]};
            c = d[0];
         end
         default: begin
            r = d;
            c = cin;
         end
      endcase
      lat = 1 + (eff + S - 1) / S;
   endfunction

   // Driver: issue one op, wait for done, score result, carry, latency and the pulse.
   task automatic run_op(input string tag, input logic imm, input logic [11:0] op,
                         input logic [W-1:0] val, input logic [7:0] amt,
                         input logic [2:0] ty, input logic cin,
                         input logic [W-1:0] exp_res, input logic exp_c, input int exp_lat);
      int          lat;
      logic [W:0]  e;
      @(negedge clk);
      chk({tag, " hold_res"}, 64'(result), 64'(hold_res));
      chk({tag, " hold_c"}, 64'(carry_out), 64'(hold_c));
      imm_mode = imm; operand = op; value = val; amount = amt;
      shift_type = ty; carry_in = cin; start = 1'b1;
      exp_q.push_back({exp_c, exp_res});
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " done_seen"}, 64'(done), 64'd1);
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, " result"}, 64'(result), 64'(e[W-1:0]));
         chk({tag, " carry"}, 64'(carry_out), 64'(e[W]));
      end
      @(posedge clk);
      #1;
      chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
      chk({tag, " idle_after"}, 64'(busy), 64'd0);
      hold_res = exp_res;
      hold_c   = exp_c;
   endtask

   function automatic vec_t mk(input logic imm, input logic [11:0] op, input logic [W-1:0] val,
                               input logic [7:0] amt, input logic [2:0] ty, input logic cin,
                               input logic [W-1:0] er, input logic ec, input int el);
      vec_t v;
      v.imm = imm; v.op = op; v.val = val; v.amt = amt; v.ty = ty; v.cin = cin;
      v.exp_res = er; v.exp_c = ec; v.exp_lat = el;
      return v;
   endfunction

   initial begin
      logic [W-1:0] r;
      logic         c;
      int           lat;
      int           done_cnt;
      logic         rimm;
      logic [11:0]  rop;
      logic [W-1:0] rval;
      logic [7:0]   ramt;
      logic [2:0]   rty;
      logic         rcin;

      reset = 1'b1; start = 1'b0; imm_mode = 1'b0; operand = '0; value = '0;
      amount = '0; shift_type = '0; carry_in = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset result", 64'(result), 64'd0);
      chk("reset carry", 64'(carry_out), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      hold_res = '0;
      hold_c   = 1'b0;

      // Directed vectors: imm, operand, value, amount, type, cin -> result, C, latency.
      vecs.push_back(mk(0, 12'h000, 32'h0000_0001,   4, 0, 1, 32'h0000_0010, 0,  2));
      vecs.push_back(mk(0, 12'h000, 32'h8000_0000,  32, 1, 0, 32'h0000_0000, 1,  9));
      vecs.push_back(mk(0, 12'h000, 32'h8000_0000,  33, 1, 1, 32'h0000_0000, 0, 10));
      vecs.push_back(mk(0, 12'h000, 32'h8000_0000,  40, 2, 0, 32'hFFFF_FFFF, 1, 10));
      vecs.push_back(mk(1, 12'h4FF, 32'h1234_5678, 200, 1, 0, 32'hFF00_0000, 1,  3));
      vecs.push_back(mk(0, 12'h000, 32'h8000_0001,  64, 3, 0, 32'h8000_0001, 1,  1));
      vecs.push_back(mk(0, 12'h000, 32'h0000_0003,   9, 4, 1, 32'h8000_0001, 1,  1));
      vecs.push_back(mk(0, 12'h000, 32'h1234_5678,  17, 6, 1, 32'h1234_5678, 1,  1));
      vecs.push_back(mk(0, 12'h000, 32'h0000_00A5,   0, 3, 1, 32'h0000_00A5, 1,  1));
      vecs.push_back(mk(0, 12'h000, 32'hDEAD_BEEF,   0, 0, 0, 32'hDEAD_BEEF, 0,  1));
      vecs.push_back(mk(0, 12'h000, 32'h0000_0001,  32, 0, 0, 32'h0000_0000, 1,  9));
      vecs.push_back(mk(0, 12'h000, 32'hFFFF_FFFF,  33, 0, 1, 32'h0000_0000, 0, 10));
      vecs.push_back(mk(0, 12'h000, 32'h7FFF_FFFF, 255, 2, 1, 32'h0000_0000, 0, 10));
      vecs.push_back(mk(0, 12'h000, 32'h0000_000F,   4, 3, 0, 32'hF000_0000, 1,  2));
      vecs.push_back(mk(0, 12'h000, 32'h0000_000C,   3, 1, 0, 32'h0000_0001, 1,  2));
      vecs.push_back(mk(0, 12'h000, 32'h8000_0000,   5, 2, 1, 32'hFC00_0000, 0,  3));
      vecs.push_back(mk(0, 12'h000, 32'h0000_0002,  33, 3, 1, 32'h0000_0001, 0,  2));
      vecs.push_back(mk(1, 12'h000, 32'hFFFF_FFFF,  12, 0, 1, 32'h0000_0000, 1,  1));
      vecs.push_back(mk(0, 12'h000, 32'h8000_0000,   1, 0, 0, 32'h0000_0000, 1,  2));

      for (int i = 0; i < vecs.size(); i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].imm, vecs[i].op, vecs[i].val, vecs[i].amt,
                vecs[i].ty, vecs[i].cin, vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_lat);
      end

      // Random ops against the reference model.
      for (int i = 0; i < 150; i++) begin
         rimm = ($urandom_range(0, 3) == 0);
         rop  = 12'($urandom_range(0, 4095));
         rval = $urandom;
         ramt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 40));
         rty  = 3'($urandom_range(0, 7));
         rcin = 1'($urandom_range(0, 1));
         model(rimm, rop, rval, ramt, rty, rcin, r, c, lat);
         run_op($sformatf("rnd%0d", i), rimm, rop, rval, ramt, rty, rcin, r, c, lat);
      end

      // Start held high through the whole op (and its DONE cycle) is ignored.
      @(negedge clk);
      imm_mode = 1'b0; value = 32'h0000_0003; amount = 8'd12; shift_type = 3'd0;
      carry_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      value = 32'hFFFF_FFFF; amount = 8'd1; shift_type = 3'd1;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("hold_start latency", 64'(lat), 64'd4);
      chk("hold_start result", 64'(result), 64'h0000_3000);
      chk("hold_start carry", 64'(carry_out), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_in_done busy", 64'(busy), 64'd0);
      chk("start_in_done done", 64'(done), 64'd0);
      chk("start_in_done result", 64'(result), 64'h0000_3000);

      // LSL 20, second start at cycle 2 (ignored), reset at cycle 3 aborts.
      @(negedge clk);
      value = 32'h0000_0001; amount = 8'd20; shift_type = 3'd0; carry_in = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      value = 32'h0000_0005; shift_type = 3'd4; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort result", 64'(result), 64'd0);
      chk("abort carry", 64'(carry_out), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      chk("abort no_done", 64'(done_cnt), 64'd0);
      chk("abort result_after", 64'(result), 64'd0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      reset = 1'b1; start = 1'b1; value = 32'h0000_0001; amount = 8'd4; shift_type = 3'd0;
      @(posedge clk);
      #1;
      chk("reset_prio busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      chk("reset_prio no_done", 64'(done_cnt), 64'd0);
      chk("reset_prio result", 64'(result), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
